// File: rtl/serial_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx_frame #(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_ser,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int DIV_W = $clog2(BIT_DIV) + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  logic parity_q, parity_d;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tx_ser_q, tx_ser_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_busy_q, tx_busy_d;
  logic             div_last_s;
  logic             bit_last_s;

  // With BIT_DIV=1 every cycle ends a bit period, so the divider never counts.
  assign div_last_s = (BIT_DIV == 1) ? 1'b1 : (div_cnt_q == DIV_LAST);
  assign bit_last_s = (bit_cnt_q == BIT_LAST);

  // Next-state, counter and shift-register computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q == ST_IDLE || div_last_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_START;
          shift_d   = in_data;
          bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = parity_of(in_data);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (div_last_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (div_last_s) begin
          shift_d = shift_q >> 1'b1;
          if (bit_last_s) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          shift_d = shift_q;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (div_last_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (div_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line matches the state it enters.
  always_comb begin
    tx_busy_d = (state_d != ST_IDLE);
    tx_done_d = (state_d == ST_STOP) && (div_cnt_d == DIV_LAST);
    case (state_d)
      ST_IDLE:   tx_ser_d = 1'b1;
      ST_START:  tx_ser_d = 1'b0;
      ST_DATA:   tx_ser_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_ser_d = parity_d;
`endif
      ST_STOP:   tx_ser_d = 1'b1;
      default:   tx_ser_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      tx_ser_q  <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      tx_ser_q  <= tx_ser_d;
      tx_done_q <= tx_done_d;
      tx_busy_q <= tx_busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign tx_ser   = tx_ser_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: one instance with BIT_DIV=1 (a_*) and one with BIT_DIV=4 (b_*).
module tb_serial_tx_frame;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, a_ser, a_busy, a_done;
  logic       b_ready, b_ser, b_busy, b_done;
  int         checks = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serial_tx_frame #(.WIDTH(8), .BIT_DIV(1)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .tx_ser(a_ser), .tx_busy(a_busy), .tx_done(a_done)
  );

  serial_tx_frame #(.WIDTH(8), .BIT_DIV(4)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .tx_ser(b_ser), .tx_busy(b_busy), .tx_done(b_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying w.
  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
`ifdef SERIAL_TX_PARITY_EN
    if (k == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_a_ser"}, a_ser, 1);
    check_eq({tag, "_a_ready"}, a_ready, 1);
    check_eq({tag, "_a_busy"}, a_busy, 0);
    check_eq({tag, "_a_done"}, a_done, 0);
    check_eq({tag, "_b_ser"}, b_ser, 1);
    check_eq({tag, "_b_ready"}, b_ready, 1);
    check_eq({tag, "_b_busy"}, b_busy, 0);
    check_eq({tag, "_b_done"}, b_done, 0);
  endtask

  // Send one word and check every cycle of its frame; mid is written to in_data halfway through.
  task automatic send_frame(input bit sel, input logic [7:0] w, input int div, input logic [7:0] mid);
    int len;
    len = FB * div;
    @(negedge clk);
    if (sel) begin b_data = w; b_valid = 1'b1; end
    else begin a_data = w; a_valid = 1'b1; end
    check_eq("hs_ready", sel ? b_ready : a_ready, 1);
    @(negedge clk);
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (c == len / 2) begin
        if (sel) b_data = mid; else a_data = mid;
      end
      check_eq("ser", sel ? b_ser : a_ser, frame_bit(w, c / div));
      check_eq("done", sel ? b_done : a_done, (c == len - 1) ? 1 : 0);
      check_eq("busy", sel ? b_busy : a_busy, 1);
      check_eq("ready_busy", sel ? b_ready : a_ready, 0);
    end
    @(negedge clk);
    check_eq("post_ready", sel ? b_ready : a_ready, 1);
    check_eq("post_busy", sel ? b_busy : a_busy, 0);
    check_eq("post_ser", sel ? b_ser : a_ser, 1);
    check_eq("post_done", sel ? b_done : a_done, 0);
  endtask

  initial begin
    int total;
    logic exp_bit;

    // Reset hold with in_valid toggling.
    #2;
    for (int i = 0; i < 4; i++) begin
      a_valid = ~a_valid;
      b_valid = ~b_valid;
      a_data  = 8'hA5;
      b_data  = 8'h3C;
      #4;
      check_idle("rst_hold");
      #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Single frame, BIT_DIV=1; then the parity-relevant second word.
    send_frame(1'b0, 8'hA5, 1, 8'h5A);
    send_frame(1'b0, 8'h07, 1, 8'hF8);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    a_data  = 8'h01;
    a_valid = 1'b1;
    @(negedge clk);
    total = 2 * FB + 1;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) a_data = 8'hFF;
      if (c < FB) exp_bit = frame_bit(8'h01, c);
      else if (c == FB) exp_bit = 1'b1;
      else exp_bit = frame_bit(8'hFF, c - FB - 1);
      check_eq("b2b_ser", a_ser, exp_bit);
      check_eq("b2b_done", a_done, (c == FB - 1 || c == total - 1) ? 1 : 0);
      check_eq("b2b_ready", a_ready, (c == FB) ? 1 : 0);
      if (c == total - 1) a_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("b2b_end_ready", a_ready, 1);
    check_eq("b2b_end_ser", a_ser, 1);

    // Divider: 4 cycles per bit, in_data cleared mid-frame.
    send_frame(1'b1, 8'h3C, 4, 8'h00);

    // Reset during data bit 3 of 8'hAA.
    @(negedge clk);
    b_data  = 8'hAA;
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check_eq("mid_start", b_ser, 0);
    repeat (17) @(negedge clk);
    check_eq("mid_busy_pre", b_busy, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ser", b_ser, 1);
    check_eq("mid_rst_busy", b_busy, 0);
    check_eq("mid_rst_ready", b_ready, 1);
    check_eq("mid_rst_done", b_done, 0);
    @(negedge clk);
    check_eq("mid_rst_done2", b_done, 0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_rel");
    send_frame(1'b1, 8'h55, 4, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
